// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (a, b) round-robin arbiter in front of a single-port
//            synchronous memory. One command is accepted per arbitration in
//            IDLE. A write occupies IDLE->ISSUE (2 cycles). A read occupies
//            IDLE->ISSUE->RDATA (3 cycles); the memory returns data one cycle
//            after mem_rd_en.
// Ports    : clk, reset (async, active-high)
//            req_x/we_x/addr_x/wdata_x      requester command inputs (x = a, b)
//            gnt_x                          one-cycle grant pulse (ISSUE)
//            rvalid_x/rdata_x               read return (RDATA); rdata_x is 0
//                                           whenever rvalid_x is low
//            mem_addr/mem_wr_en/mem_rd_en/mem_wdata   memory command
//            mem_rdata                      registered memory read data
//            busy                           high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t state_q, state_d;

  // last_b: 1 when requester b received the most recent grant
  logic last_b_q, last_b_d;

  // Latched command of the current transaction
  logic                  cmd_b_q,     cmd_b_d;
  logic                  cmd_we_q,    cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  // Registered outputs
  logic gnt_a_q,     gnt_a_d;
  logic gnt_b_q,     gnt_b_d;
  logic rvalid_a_q,  rvalid_a_d;
  logic rvalid_b_q,  rvalid_b_d;
  logic mem_wr_en_q, mem_wr_en_d;
  logic mem_rd_en_q, mem_rd_en_d;
  logic busy_q,      busy_d;

  // Arbitration result for the current cycle's requests
  logic                  pick_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // b wins when it is the only requester, or on contention when a was
  // granted last.
  always_comb begin
    pick_b    = req_b & (~req_a | ~last_b_q);
    sel_we    = pick_b ? we_b    : we_a;
    sel_addr  = pick_b ? addr_b  : addr_a;
    sel_wdata = pick_b ? wdata_b : wdata_a;
  end

  // Next-state and next-output logic. Output flops are loaded with the values
  // belonging to the state being entered, so they are valid for that state.
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    cmd_b_d     = cmd_b_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          state_d     = ISSUE;
          last_b_d    = pick_b;
          cmd_b_d     = pick_b;
          cmd_we_d    = sel_we;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          gnt_a_d     = ~pick_b;
          gnt_b_d     = pick_b;
          mem_wr_en_d = sel_we;
          mem_rd_en_d = ~sel_we;
          busy_d      = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_we_q) begin
          state_d = IDLE;
        end else begin
          // Memory registers the read at this edge; data is valid in RDATA.
          state_d    = RDATA;
          rvalid_a_d = ~cmd_b_q;
          rvalid_b_d = cmd_b_q;
          busy_d     = 1'b1;
        end
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;  // a wins the first contention after reset
      cmd_b_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      cmd_b_q     <= cmd_b_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = busy_q;
  assign mem_addr  = cmd_addr_q;

  // Read data arrives from the memory register during RDATA only, so it is
  // gated by the registered valid rather than re-registered here.
  assign rdata_a   = rvalid_a_q  ? mem_rdata   : '0;
  assign rdata_b   = rvalid_b_q  ? mem_rdata   : '0;
  assign mem_wdata = mem_wr_en_q ? cmd_wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a 4x8 memory (reset
//            fills 0xFF). A transaction-schedule model predicts every output
//            each cycle; directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic gnt_a, rvalid_a, gnt_b, rvalid_b, mem_wr_en, mem_rd_en, busy;
  logic [DW-1:0] rdata_a, rdata_b, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- memory attached to the arbiter ----------------
  logic [DW-1:0] mem [4];
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 4; i++) mem[i] = 8'hFF;
        mem_rdata = '0;
      end else begin
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
        if (mem_rd_en) mem_rdata = mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: per-cycle expected outputs ----------------
  // A granted command occupies one slot (grant/issue) and, for a read, a
  // second slot (data return). New commands are taken only when the cycle
  // just ending had no transaction in flight.
  typedef struct {
    logic ga, gb, va, vb, wr, rd, busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] da, db, wd;
  } exp_t;

  exp_t cur, nxt;
  logic [DW-1:0] mmem [4];
  logic m_last_b;

  function automatic exp_t empty_slot();
    exp_t s;
    s.ga = 0; s.gb = 0; s.va = 0; s.vb = 0; s.wr = 0; s.rd = 0; s.busy = 0;
    s.addr = '0; s.da = '0; s.db = '0; s.wd = '0;
    return s;
  endfunction

  task automatic model_reset();
    cur = empty_slot();
    nxt = empty_slot();
    m_last_b = 1'b1;
    for (int i = 0; i < 4; i++) mmem[i] = 8'hFF;
  endtask

  task automatic model_step();
    logic was_idle, wb, w;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    if (cur.wr) mmem[cur.addr] = cur.wd;
    was_idle = !cur.busy;
    cur = nxt;
    nxt = empty_slot();
    if (was_idle && (req_a || req_b)) begin
      wb = req_b && (!req_a || !m_last_b);
      m_last_b = wb;
      w  = wb ? we_b : we_a;
      ad = wb ? addr_b : addr_a;
      wd = wb ? wdata_b : wdata_a;
      cur.busy = 1; cur.ga = !wb; cur.gb = wb; cur.addr = ad;
      cur.wr = w; cur.rd = !w; cur.wd = w ? wd : '0;
      if (!w) begin
        nxt.busy = 1; nxt.va = !wb; nxt.vb = wb;
        if (wb) nxt.db = mmem[ad]; else nxt.da = mmem[ad];
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  logic prev_ga = 0, prev_gb = 0;
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt_a", 32'(gnt_a), 32'(cur.ga));
      chk("gnt_b", 32'(gnt_b), 32'(cur.gb));
      chk("rvalid_a", 32'(rvalid_a), 32'(cur.va));
      chk("rvalid_b", 32'(rvalid_b), 32'(cur.vb));
      chk("rdata_a", 32'(rdata_a), 32'(cur.da));
      chk("rdata_b", 32'(rdata_b), 32'(cur.db));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(cur.wr));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(cur.rd));
      chk("mem_wdata", 32'(mem_wdata), 32'(cur.wd));
      chk("busy", 32'(busy), 32'(cur.busy));
      if (cur.wr || cur.rd) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
      chk("wr_rd_exclusive", 32'(mem_wr_en & mem_rd_en), 32'd0);
      chk("gnt_exclusive", 32'(gnt_a & gnt_b), 32'd0);
      chk("rvalid_exclusive", 32'(rvalid_a & rvalid_b), 32'd0);
      chk("gnt_a_one_cycle", 32'(gnt_a & prev_ga), 32'd0);
      chk("gnt_b_one_cycle", 32'(gnt_b & prev_gb), 32'd0);
      chk("rdata_a_zero", rvalid_a ? 32'd0 : 32'(rdata_a), 32'd0);
      chk("rdata_b_zero", rvalid_b ? 32'd0 : 32'(rdata_b), 32'd0);
      prev_ga = gnt_a;
      prev_gb = gnt_b;
    end
  end

  // ---------------- requester agents ----------------
  logic pend_a = 0, pend_b = 0;
  int   hold_a = 0, hold_b = 0;   // extra grants to keep req held through
  logic cwe_a = 0, cwe_b = 0;
  logic [AW-1:0] caddr_a = '0, caddr_b = '0;
  logic [DW-1:0] cwd_a = '0, cwd_b = '0;
  string glog = "";
  int wr_pulses = 0;

  task automatic tick();
    @(negedge clk);
    if (gnt_a) glog = {glog, "a"};
    if (gnt_b) glog = {glog, "b"};
    if (mem_wr_en) wr_pulses++;
    if (req_a && gnt_a) begin
      if (hold_a > 0) hold_a--;
      else begin
        req_a = 0; pend_a = 0;
        we_a = 1'($urandom_range(0, 1)); addr_a = AW'($urandom); wdata_a = DW'($urandom);
      end
    end
    if (req_b && gnt_b) begin
      if (hold_b > 0) hold_b--;
      else begin
        req_b = 0; pend_b = 0;
        we_b = 1'($urandom_range(0, 1)); addr_b = AW'($urandom); wdata_b = DW'($urandom);
      end
    end
    if (pend_a && !req_a) begin req_a = 1; we_a = cwe_a; addr_a = caddr_a; wdata_a = cwd_a; end
    if (pend_b && !req_b) begin req_b = 1; we_b = cwe_b; addr_b = caddr_b; wdata_b = cwd_b; end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!busy && !req_a && !req_b && !pend_a && !pend_b) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle at %0t", $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    req_a = 0; req_b = 0; pend_a = 0; pend_b = 0; hold_a = 0; hold_b = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic set_a(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    cwe_a = w; caddr_a = ad; cwd_a = d; pend_a = 1;
  endtask

  task automatic set_b(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    cwe_b = w; caddr_b = ad; cwd_b = d; pend_b = 1;
  endtask

  // ---------------- main sequence ----------------
  string exp_order = "abab";

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 0;

    // single read by a of addr 2
    set_a(1'b0, 2'd2, 8'h00);
    tick();
    tick();
    chk("s1_gnt_a", 32'(gnt_a), 32'd1);
    chk("s1_gnt_b", 32'(gnt_b), 32'd0);
    chk("s1_mem_rd_en", 32'(mem_rd_en), 32'd1);
    chk("s1_mem_addr", 32'(mem_addr), 32'd2);
    tick();
    chk("s1_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("s1_rdata_a", 32'(rdata_a), 32'hFF);
    chk("s1_rvalid_b", 32'(rvalid_b), 32'd0);
    chk("s1_rdata_b", 32'(rdata_b), 32'd0);
    wait_idle();

    // b writes 0x5A to addr 1, then a reads addr 1
    wr_pulses = 0;
    set_b(1'b1, 2'd1, 8'h5A);
    tick();
    tick();
    chk("s2_gnt_b", 32'(gnt_b), 32'd1);
    chk("s2_mem_wr_en", 32'(mem_wr_en), 32'd1);
    chk("s2_mem_wdata", 32'(mem_wdata), 32'h5A);
    chk("s2_mem_addr", 32'(mem_addr), 32'd1);
    set_a(1'b0, 2'd1, 8'h00);
    tick();
    chk("s2_write_done_busy", 32'(busy), 32'd0);
    tick();
    chk("s2_gnt_a", 32'(gnt_a), 32'd1);
    tick();
    chk("s2_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("s2_rdata_a", 32'(rdata_a), 32'h5A);
    wait_idle();
    chk("s2_wr_pulses", 32'(wr_pulses), 32'd1);

    // both hold read requests from the same cycle after reset
    do_reset();
    glog = "";
    set_a(1'b0, 2'd0, 8'h00); hold_a = 10;
    set_b(1'b0, 2'd3, 8'h00); hold_b = 10;
    tick();
    repeat (12) tick();
    chk("s3_grant_count_ge4", 32'(glog.len() >= 4), 32'd1);
    if (glog.len() >= 4)
      for (int i = 0; i < 4; i++) chk("s3_grant_order", 32'(glog[i]), 32'(exp_order[i]));
    hold_a = 0; hold_b = 0; pend_a = 0; pend_b = 0; req_a = 0; req_b = 0;
    wait_idle();

    // b's addr changes during ISSUE of its read of addr 0
    set_a(1'b1, 2'd0, 8'h11); wait_idle();
    set_a(1'b1, 2'd3, 8'h33); wait_idle();
    set_b(1'b0, 2'd0, 8'h00);
    tick();
    tick();
    chk("s4_gnt_b", 32'(gnt_b), 32'd1);
    addr_b = 2'd3;
    chk("s4_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    chk("s4_rvalid_b", 32'(rvalid_b), 32'd1);
    chk("s4_rdata_b", 32'(rdata_b), 32'h11);
    wait_idle();

    // reset during RDATA of a read by a
    set_a(1'b0, 2'd2, 8'h00);
    tick();
    tick();
    chk("s5_gnt_a", 32'(gnt_a), 32'd1);
    @(posedge clk);
    #1;
    reset = 1; pend_a = 0; req_a = 0;
    tick();
    chk("s5_rvalid_a_abort", 32'(rvalid_a), 32'd0);
    chk("s5_busy_abort", 32'(busy), 32'd0);
    tick();
    reset = 0;
    set_a(1'b0, 2'd1, 8'h00);
    tick();
    tick();
    chk("s5_gnt_a_after", 32'(gnt_a), 32'd1);
    tick();
    chk("s5_rvalid_a_after", 32'(rvalid_a), 32'd1);
    chk("s5_rdata_a_after", 32'(rdata_a), 32'hFF);
    wait_idle();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (!pend_a && !req_a && $urandom_range(0, 2) == 0) begin
        cwe_a = 1'($urandom_range(0, 1)); caddr_a = AW'($urandom); cwd_a = DW'($urandom);
        hold_a = ($urandom_range(0, 3) == 0) ? 1 : 0;
        pend_a = 1;
      end
      if (!pend_b && !req_b && $urandom_range(0, 2) == 0) begin
        cwe_b = 1'($urandom_range(0, 1)); caddr_b = AW'($urandom); cwd_b = DW'($urandom);
        hold_b = ($urandom_range(0, 3) == 0) ? 1 : 0;
        pend_b = 1;
      end
      tick();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have, for each requester x in {a, b}, the inputs req_x (1, request), we_x (1, 1=write 0=read), addr_x (ADDR_WIDTH) and wdata_x (DATA_WIDTH).
REQ-006 SHALL have, for each requester x, the outputs gnt_x (1, one-cycle grant pulse), rvalid_x (1, read data valid) and rdata_x (DATA_WIDTH).
REQ-007 SHALL have memory-side outputs mem_addr (ADDR_WIDTH), mem_wr_en (1), mem_rd_en (1) and mem_wdata (DATA_WIDTH).
REQ-008 SHALL have memory-side input mem_rdata (DATA_WIDTH), which is registered by the memory one cycle after mem_rd_en.
REQ-009 SHALL have output busy (1), high in every state except IDLE.

Function
REQ-010 SHALL implement the FSM states IDLE, ISSUE and RDATA.
REQ-011 In IDLE with no req_x high, SHALL remain in IDLE with all memory enables low.
REQ-012 In IDLE with at least one req_x high, SHALL select one winner, latch its we, addr and wdata, and go to ISSUE.
REQ-013 SHALL arbitrate round-robin: with a single requester, that requester wins; with both, the requester not granted last wins.
REQ-014 SHALL use a last_grant register that updates only when a grant is issued.
REQ-015 In ISSUE, SHALL drive mem_addr from the latched address and pulse gnt of the winner for exactly one cycle.
REQ-016 In ISSUE for a write, SHALL drive mem_wr_en=1 and mem_wdata from the latched data, then go to IDLE.
REQ-017 In ISSUE for a read, SHALL drive mem_rd_en=1, then go to RDATA.
REQ-018 In RDATA, SHALL drive rvalid of the winner high for exactly one cycle with rdata of the winner equal to mem_rdata, then go to IDLE.
REQ-019 SHALL give the following latencies from the edge that samples req in IDLE: gnt 1 cycle later; a read's rvalid 2 cycles later.
REQ-020 SHALL accept at most one write per 2 cycles and one read per 3 cycles.
REQ-021 SHALL never assert mem_wr_en and mem_rd_en together, and never assert gnt_a and gnt_b together.
REQ-022 SHALL never assert rvalid_a and rvalid_b together.
REQ-023 SHALL drive rdata_x to 0 whenever rvalid_x is low.
REQ-024 SHALL drive mem_wdata to 0 whenever mem_wr_en is low.
REQ-025 Requesters SHALL hold req/we/addr/wdata until gnt; the arbiter SHALL ignore changes after the latch point.
REQ-026 A requester SHALL deassert req in the cycle gnt is seen; if req is still high on the next IDLE, it is treated as a new request.
REQ-027 SHALL ignore a req_x that rises while busy until the next IDLE arbitration; no request is lost while it is held.
REQ-028 With both requesters held high, SHALL alternate grants a, b, a, b, ... with no starvation.

Reset
REQ-029 While reset=1, SHALL force state=IDLE and last_grant=b, so a wins the first contention.
REQ-030 While reset=1, SHALL drive gnt_x, rvalid_x, mem_wr_en, mem_rd_en and busy to 0.
REQ-031 While reset=1, SHALL drive mem_addr, mem_wdata, rdata_x and the latched command to 0.
REQ-032 Reset asserted mid-transaction (ISSUE or RDATA) SHALL abort it: no gnt or rvalid is issued after reset, and arbitration restarts fresh after release.

Verification (bench instantiates the arbiter plus the 4x8 memory; memory reset fills 0xFF)
REQ-033 After reset, a single read by a of addr 2 -> gnt_a 1 cycle after sampling; rvalid_a 2 cycles after sampling with rdata_a=0xFF; b outputs stay 0.
REQ-034 b writes 0x5A to addr 1, then a reads addr 1 -> mem_wr_en pulses once with mem_wdata=0x5A; a then gets rvalid_a with rdata_a=0x5A.
REQ-035 After reset, a and b both raise read requests in the same cycle and hold them -> grants in order a, b, a, b; gnt_a and gnt_b never high together.
REQ-036 b changes addr_b from 0 to 3 during ISSUE of its read of addr 0 -> mem_addr=0 and the data returned is that of addr 0.
REQ-037 Reset asserted in the RDATA cycle of a read by a -> rvalid_a stays 0; after release, a new request by a is granted with the normal 1-cycle latency.
REQ-038 Throughout all scenarios, assert that mem_wr_en and mem_rd_en are mutually exclusive, gnt_x is one cycle wide, busy is 0 exactly in IDLE, and rdata_x=0 whenever rvalid_x=0.
